// File: rtl/iot_tty.sv
// iot_tty -- teletype keyboard/printer pair on a PDP-8 style IOT bus.
//
// Keyboard half: one-character buffer filled from a host valid/ready stream;
// kbd_flag marks "character waiting". Printer half: one-character buffer sent
// to the host over valid/ready, then a fixed PRINT_DELAY busy period before
// prn_flag reports "printer done".
//
// Ports
//   clock, resetN           clock, async active-low reset
//   iot_valid/dev/fn        IOT strobe, device code IR[8:3], function IR[2:0]
//   dataout                 AC[7:0] from the CPU
//   iot_ack/datain/iot_skip/iot_clr_ac  registered IOT response, one cycle
//   irq                     kbd_flag | prn_flag
//   kbd_valid/data/ready    host -> keyboard character stream
//   prn_valid/data/ready    printer -> host character stream
module iot_tty #(
  parameter logic [5:0] KBD_DEV     = 6'o03,
  parameter logic [5:0] PRN_DEV     = 6'o04,
  parameter int         PRINT_DELAY = 16
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       iot_valid,
  input  logic [5:0] iot_dev,
  input  logic [2:0] iot_fn,
  input  logic [7:0] dataout,
  output logic       iot_ack,
  output logic [7:0] datain,
  output logic       iot_skip,
  output logic       iot_clr_ac,
  output logic       irq,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       prn_valid,
  output logic [7:0] prn_data,
  input  logic       prn_ready
);

  typedef enum logic [1:0] {P_IDLE, P_SEND, P_WAIT} pstate_t;

  localparam logic [7:0] DLY_M1 = 8'(PRINT_DELAY - 1);

  pstate_t    r_pstate;
  logic [7:0] r_cnt;
  logic [7:0] r_kbd_buf, r_prn_buf;
  logic       r_kbd_flag, r_prn_flag;
  logic       r_ack, r_skip, r_clr_ac;
  logic [7:0] r_datain;
  logic       r_prn_valid;
  logic [7:0] r_prn_data;

  logic w_kbd_hit, w_prn_hit;
  logic w_kbd_acc, w_kbd_clr;
  logic w_prn_busy, w_prn_load, w_prn_set_iot, w_prn_clr, w_prn_done;

  assign w_kbd_hit = iot_valid && (iot_dev == KBD_DEV);
  assign w_prn_hit = iot_valid && (iot_dev == PRN_DEV);

  // fn 0 (KCF) clears without the bit1 code, every bit1 code clears too.
  assign w_kbd_acc = kbd_valid && !r_kbd_flag;
  assign w_kbd_clr = w_kbd_hit && ((iot_fn == 3'd0) || iot_fn[1]);

  // Loads while busy are acked and dropped; TLS must then leave the flag alone.
  assign w_prn_busy    = (r_pstate != P_IDLE);
  assign w_prn_load    = w_prn_hit && iot_fn[2] && !w_prn_busy;
  assign w_prn_set_iot = w_prn_hit && (iot_fn == 3'd0);
  assign w_prn_clr     = w_prn_hit && iot_fn[1] && !(iot_fn[2] && w_prn_busy);
  assign w_prn_done    = (r_pstate == P_WAIT) && (r_cnt == 8'd0);

  // IOT response: skip tests see the flag before this instruction's clear.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_ack    <= 1'b0;
      r_skip   <= 1'b0;
      r_clr_ac <= 1'b0;
      r_datain <= 8'h00;
    end else begin
      r_ack    <= w_kbd_hit || w_prn_hit;
      r_skip   <= (w_kbd_hit && iot_fn[0] && r_kbd_flag) ||
                  (w_prn_hit && iot_fn[0] && r_prn_flag);
      r_clr_ac <= w_kbd_hit && iot_fn[1];
      r_datain <= (w_kbd_hit && iot_fn[2]) ? r_kbd_buf : 8'h00;
    end
  end

  // Keyboard: an accepted character beats a same-edge flag clear.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_kbd_buf  <= 8'h00;
      r_kbd_flag <= 1'b0;
    end else begin
      if (w_kbd_acc) r_kbd_buf <= kbd_data;
      if (w_kbd_acc)      r_kbd_flag <= 1'b1;
      else if (w_kbd_clr) r_kbd_flag <= 1'b0;
    end
  end

  // Printer FSM: SEND holds valid/data until ready, WAIT counts the delay.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_pstate    <= P_IDLE;
      r_cnt       <= 8'h00;
      r_prn_buf   <= 8'h00;
      r_prn_valid <= 1'b0;
      r_prn_data  <= 8'h00;
      r_prn_flag  <= 1'b0;
    end else begin
      case (r_pstate)
        P_IDLE: if (w_prn_load) begin
          r_prn_buf   <= dataout;
          r_prn_valid <= 1'b1;
          r_prn_data  <= dataout;
          r_pstate    <= P_SEND;
        end
        P_SEND: if (prn_ready) begin
          r_prn_valid <= 1'b0;
          r_prn_data  <= 8'h00;
          r_cnt       <= DLY_M1;
          r_pstate    <= P_WAIT;
        end
        P_WAIT: begin
          if (r_cnt == 8'd0) r_pstate <= P_IDLE;
          else               r_cnt    <= r_cnt - 8'd1;
        end
        default: r_pstate <= P_IDLE;
      endcase
      // Completion beats a same-edge TCF/TLS clear.
      if (w_prn_done || w_prn_set_iot) r_prn_flag <= 1'b1;
      else if (w_prn_clr)              r_prn_flag <= 1'b0;
    end
  end

  assign iot_ack    = r_ack;
  assign iot_skip   = r_skip;
  assign iot_clr_ac = r_clr_ac;
  assign datain     = r_datain;
  assign irq        = r_kbd_flag | r_prn_flag;
  assign kbd_ready  = ~r_kbd_flag;
  assign prn_valid  = r_prn_valid;
  assign prn_data   = r_prn_data;

endmodule
